seq_mul_ct: RTL and testbench

//  Parametrised iterative shift-and-add multiplier with valid/ready handshakes on both sides.

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_pp_step.sv | 23 ++
 rtl/seq_mul_ct.sv | 132 +++++++++++++
 tb/tb_seq_mul_ct.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state type and sizing helpers for the iterative multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic int steps(input int width, input int k);
    return width / k;
  endfunction

  function automatic int cnt_w(input int width, input int k);
    return $clog2(width / k) + 1;
  endfunction

endpackage

// File: rtl/mul_pp_step.sv
// rtl/mul_pp_step.sv - one shift-and-add step: acc plus a K-bit partial product at slot cnt
module mul_pp_step #(
  parameter int WIDTH = 8,
  parameter int K     = 1,
  parameter int CW    = 4
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [K-1:0]       b_i,
  input  logic [CW-1:0]      cnt_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH+K-1:0]   pp;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [31:0]          shamt;

  assign pp     = {{K{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
  assign pp_ext = (2*WIDTH)'(pp);
  assign shamt  = 32'(cnt_i) * 32'(K);
  assign acc_o  = acc_i + (pp_ext << shamt);

endmodule

// File: rtl/seq_mul_ct.sv
// rtl/seq_mul_ct.sv - iterative multiplier with constant-time / early-exit modes and valid/ready handshakes
module seq_mul_ct
  import mul_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int K         = 1,
  parameter int SIGNED_EN = 1,
  localparam int STEPS    = steps(WIDTH, K),
  localparam int CW       = cnt_w(WIDTH, K)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic               in_ct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [CW-1:0]      out_cycles
);

  localparam int PW = 2 * WIDTH;

  if ((WIDTH % K) != 0) begin : g_bad_k
    $error("seq_mul_ct: K must divide WIDTH");
  end

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             ct_q, ct_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CW-1:0]    cyc_q, cyc_d;

  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag, b_next;
  logic [PW-1:0]    acc_step;
  logic             last_step;

  // Operands are stored as magnitudes; the sign is reapplied once at the end.
  assign sgn    = (SIGNED_EN != 0) & in_signed;
  assign a_mag  = (sgn && in_a[WIDTH-1]) ? -in_a : in_a;
  assign b_mag  = (sgn && in_b[WIDTH-1]) ? -in_b : in_b;
  assign b_next = b_q >> K;

  mul_pp_step #(.WIDTH(WIDTH), .K(K), .CW(CW)) u_pp_step (
    .a_i   (a_q),
    .b_i   (b_q[K-1:0]),
    .cnt_i (cnt_q),
    .acc_i (acc_q),
    .acc_o (acc_step)
  );

  // Early exit only looks at operand state in ct=0; ct=1 always runs STEPS cycles.
  assign last_step = (cnt_q == CW'(STEPS - 1)) ||
                     (!ct_q && ((a_q == '0) || (b_next == '0)));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    ct_d    = ct_q;
    p_d     = p_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = sgn & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          ct_d    = in_ct;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_step;
        b_d   = b_next;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          p_d     = neg_q ? -acc_step : acc_step;
          cyc_d   = cnt_q + CW'(1);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ct_q    <= 1'b0;
      p_q     <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      ct_q    <= ct_d;
      p_q     <= p_d;
      cyc_q   <= cyc_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_p      = p_q;
  assign out_cycles = cyc_q;

endmodule

// File: tb/tb_seq_mul_ct.sv
// tb/tb_seq_mul_ct.sv - scoreboard bench driving K=1,2,4 copies of seq_mul_ct in lockstep
module tb_seq_mul_ct;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_signed, in_ct, out_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] ir, ov;
  logic [2:0][15:0] op;
  logic [2:0][3:0]  oc;

  exp_t sb [3][$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KK = 1 << g;
    localparam int CW = $clog2(8 / KK) + 1;
    logic [CW-1:0] cyc;
    logic [15:0]   p;
    logic          ir_w, ov_w;
    exp_t          e;

    seq_mul_ct #(.WIDTH(8), .K(KK), .SIGNED_EN(1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (ir_w),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_signed  (in_signed),
      .in_ct      (in_ct),
      .out_valid  (ov_w),
      .out_ready  (out_ready),
      .out_p      (p),
      .out_cycles (cyc)
    );

    assign ir[g] = ir_w;
    assign ov[g] = ov_w;
    assign op[g] = p;
    assign oc[g] = 4'(cyc);

    always @(negedge clk) begin
      if (rst_n && ov_w && out_ready) begin
        if (sb[g].size() == 0) begin
          chk($sformatf("spurious_k%0d", KK), 1, 0);
        end else begin
          e = sb[g].pop_front();
          chk($sformatf("p_k%0d", KK), 32'(p), 32'(e.p));
          chk($sformatf("cyc_k%0d", KK), 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  function automatic logic [15:0] model_p(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] xa, xb;
    logic [15:0] r;
    if (s) begin
      xa = {{8{a[7]}}, a};
      xb = {{8{b[7]}}, b};
      r  = xa * xb;
    end else begin
      r = {8'd0, a} * {8'd0, b};
    end
    return r;
  endfunction

  function automatic int model_b(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 input logic ct, input int k);
    int st;
    logic [7:0] am, bm;
    st = 8 / k;
    if (ct) return st;
    am = (s && a[7]) ? 8'(-a) : a;
    bm = (s && b[7]) ? 8'(-b) : b;
    for (int c = 0; c < st; c++) begin
      if (c == st - 1 || am == 8'd0 || (bm >> k) == 8'd0) return c + 1;
      bm = bm >> k;
    end
    return st;
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ct);
    int w;
    w = 0;
    @(negedge clk);
    while (ir != 3'b111 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("idle_timeout", 0, 1);
    for (int g = 0; g < 3; g++)
      sb[g].push_back('{p: model_p(a, b, s), c: 4'(model_b(a, b, s, ct, 1 << g))});
    in_a = a; in_b = b; in_signed = s; in_ct = ct; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_a      = 8'($urandom);
    in_b      = 8'($urandom);
    in_signed = 1'($urandom);
    in_ct     = 1'($urandom);
  endtask

  task automatic drain(output int first);
    int cyc;
    first = 0;
    cyc   = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (ov[0] && first == 0) first = cyc;
      if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
    end
    if (sb[0].size() != 0 || sb[1].size() != 0 || sb[2].size() != 0) begin
      chk("drain_timeout", 0, 1);
      for (int g = 0; g < 3; g++) sb[g].delete();
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ct);
    int first;
    send(a, b, s, ct);
    drain(first);
    chk("latency_k1", 32'(first), 32'(1 + model_b(a, b, s, ct, 1)));
  endtask

  initial begin
    int l1, l2, w;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_ct = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(ir), 32'(3'b111));
    chk("rst_out_valid", 32'(ov), 0);
    chk("rst_out_p", 32'(op[0]), 0);
    chk("rst_out_cycles", 32'(oc[0]), 0);
    rst_n = 1'b1;

    run(8'd13, 8'd11, 1'b0, 1'b1);
    chk("t1_p", 32'(op[0]), 143);
    chk("t1_cyc", 32'(oc[0]), 8);
    run(8'd13, 8'd11, 1'b0, 1'b0);
    chk("t2_cyc", 32'(oc[0]), 4);
    run(8'd13, 8'd0, 1'b0, 1'b0);
    chk("t2_zero_cyc", 32'(oc[0]), 1);
    run(8'h80, 8'h80, 1'b1, 1'b1);
    chk("t3_minmin", 32'(op[0]), 16384);
    run(8'hFD, 8'd5, 1'b1, 1'b1);
    chk("t3_neg", 32'(op[0]), 32'hFFF1);
    run(8'hF9, 8'd0, 1'b1, 1'b1);
    chk("t3_negzero", 32'(op[0]), 0);
    run(8'hF9, 8'd0, 1'b1, 1'b0);
    run(8'h80, 8'h80, 1'b0, 1'b1);
    run(8'hFD, 8'd5, 1'b0, 1'b1);
    chk("t3_unsigned", 32'(op[0]), 1265);
    run(8'd255, 8'd255, 1'b0, 1'b1);
    chk("t5_k2_cyc", 32'(oc[1]), 4);
    chk("t5_k4_cyc", 32'(oc[2]), 2);
    chk("t5_k4_p", 32'(op[2]), 65025);
    run(8'd0, 8'd200, 1'b0, 1'b0);

    out_ready = 1'b0;
    send(8'd13, 8'd11, 1'b0, 1'b1);
    w = 0;
    while (!ov[0] && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) chk("bp_wait_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov), 32'(3'b111));
      chk("bp_p", 32'(op[0]), 143);
      chk("bp_in_ready", 32'(ir), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 32'(ir), 32'(3'b111));
    chk("bp_release_valid", 32'(ov), 0);

    send(8'd13, 8'd11, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ov), 0);
    chk("arst_in_ready", 32'(ir), 32'(3'b111));
    for (int g = 0; g < 3; g++) sb[g].delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(8'd7, 8'd9, 1'b0, 1'b1);
    chk("arst_after_p", 32'(op[0]), 63);

    send(8'd1, 8'h5A, 1'b0, 1'b1);
    drain(l1);
    send(8'hFF, 8'h5A, 1'b0, 1'b1);
    drain(l2);
    chk("two_copy_timing", 32'(l2), 32'(l1));

    for (int i = 0; i < 1500; i++)
      run(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
